// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped data cache controller.
package dcache_pkg;

  localparam int DCACHE_LINES = 16;
  localparam int DCACHE_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    REFILL    = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty/tag/data per line, combinational read, synchronous write.
module dcache_array #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             wrEn_i,
  input  logic [31:0]      wrData_i,
  input  logic             fillEn_i,
  input  logic [TAG_W-1:0] fillTag_i,
  input  logic [31:0]      fillData_i,
  input  logic             cleanEn_i,
  output logic             valid_o,
  output logic             dirty_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [31:0]      data_o
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

  // Only the status bits are reset; stale tags/data are harmless once valid is clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fillEn_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wrEn_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (cleanEn_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fillEn_i) begin
        tag_q[idx_i]  <= fillTag_i;
        data_q[idx_i] <= fillData_i;
      end else if (wrEn_i) begin
        data_q[idx_i] <= wrData_i;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate one-word-per-line data cache controller.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = DCACHE_LINES,
  parameter int IDX_W = DCACHE_IDX_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_write_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam int TAG_W = 30 - IDX_W;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   addrTag;
  logic               lineValid, lineDirty;
  logic [TAG_W-1:0]   lineTag;
  logic [31:0]        lineData;
  logic               hit;
  logic               hitWrite, fillEn, cleanEn;
  logic               unusedAddrBits;

  assign idx            = cpu_addr_i[IDX_W+1:2];
  assign addrTag        = cpu_addr_i[31:IDX_W+2];
  assign unusedAddrBits = ^cpu_addr_i[1:0];
  assign hit            = (state_q == IDLE) && cpu_req_i && lineValid && (lineTag == addrTag);
  assign cpu_rdata_o    = lineData;

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) uArray (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (idx),
    .wrEn_i     (hitWrite),
    .wrData_i   (cpu_wdata_i),
    .fillEn_i   (fillEn),
    .fillTag_i  (addrTag),
    .fillData_i (mem_rdata_i),
    .cleanEn_i  (cleanEn),
    .valid_o    (lineValid),
    .dirty_o    (lineDirty),
    .tag_o      (lineTag),
    .data_o     (lineData)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The CPU holds its address through a miss, so idx still selects the victim/target line.
  always_comb begin
    state_d     = state_q;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    hitWrite    = 1'b0;
    fillEn      = 1'b0;
    cleanEn     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            hitWrite = cpu_write_i;
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = (lineValid && lineDirty) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {lineTag, idx, 2'b00};
        mem_wdata_o = lineData;
        if (mem_ack_i) begin
          cleanEn = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {cpu_addr_i[31:2], 2'b00};
        if (mem_ack_i) begin
          fillEn  = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        cpu_stall_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against an array-based cache/memory reference model.
module tb_dcache_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic        cpu_write_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdata_i = '0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        mem_req_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  int vectorCount = 0;
  int missCount   = 0;
  int ackDelay    = 2;

  bit          mValid [16];
  bit          mDirty [16];
  logic [25:0] mTag   [16];
  logic [31:0] mData  [16];
  logic [31:0] bmem [logic [31:0]];

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_write_i (cpu_write_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Untouched backing-memory words hold an address-derived pattern.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    logic [31:0] key;
    key = {a[31:2], 2'b00};
    if (bmem.exists(key)) return bmem[key];
    return (key * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
  endfunction

  // Idle cycles: outputs must be quiet; optional stray acks must be ignored.
  task automatic idleCheck(input int n, input bit strayAcks);
    cpu_req_i = 1'b0;
    for (int c = 0; c < n; c++) begin
      #1;
      checkOutput("idleStall", 32'(cpu_stall_o), 32'd0);
      checkOutput("idleMemReq", 32'(mem_req_o), 32'd0);
      checkOutput("idleMemWrite", 32'(mem_write_o), 32'd0);
      checkOutput("idleMemAddr", mem_addr_o, 32'd0);
      checkOutput("idleMemWdata", mem_wdata_o, 32'd0);
      mem_ack_i   = strayAcks ? 1'($urandom) : 1'b0;
      mem_rdata_i = $urandom;
      @(posedge clk_i);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
    end
  endtask

  task automatic doReset(input int n);
    rst_i = 1'b1;
    idleCheck(n, 1'b1);
    rst_i = 1'b0;
    modelReset();
  endtask

  // One CPU access, acting as backing memory that acks in the ackDelay-th request cycle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    int          idx;
    logic [25:0] tg;
    bit          hitExp, wbExp, phaseWb, done;
    logic [31:0] victimAddr, victimData, lineAddr;
    int          expStall, stalls, reqCycles, txns;
    idx        = int'(addr[5:2]);
    tg         = addr[31:6];
    hitExp     = mValid[idx] && (mTag[idx] == tg);
    wbExp      = !hitExp && mValid[idx] && mDirty[idx];
    victimAddr = {mTag[idx], addr[5:2], 2'b00};
    victimData = mData[idx];
    lineAddr   = {addr[31:2], 2'b00};
    expStall   = hitExp ? 0 : (2 + ackDelay + (wbExp ? ackDelay : 0));
    phaseWb    = wbExp;
    done       = 1'b0;
    stalls     = 0;
    reqCycles  = 0;
    txns       = 0;
    rdata      = '0;
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      mem_ack_i = 1'b0;
      if (!cpu_stall_o) begin
        rdata = cpu_rdata_o;
        done  = 1'b1;
      end else begin
        stalls++;
        if (mem_req_o) begin
          reqCycles++;
          if (phaseWb) begin
            checkOutput("wbWrite", 32'(mem_write_o), 32'd1);
            checkOutput("wbAddr", mem_addr_o, victimAddr);
            checkOutput("wbData", mem_wdata_o, victimData);
          end else begin
            checkOutput("fetchWrite", 32'(mem_write_o), 32'd0);
            checkOutput("fetchAddr", mem_addr_o, lineAddr);
          end
          if (reqCycles == ackDelay) begin
            mem_ack_i = 1'b1;
            if (phaseWb) begin
              mem_rdata_i = $urandom;
              bmem[victimAddr] = victimData;
            end else begin
              mem_rdata_i = memRead(lineAddr);
            end
            txns++;
            reqCycles = 0;
            phaseWb   = 1'b0;
          end
        end
      end
      @(posedge clk_i);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
    end
    cpu_req_i = 1'b0;
    checkOutput("accessDone", 32'(done), 32'd1);
    checkOutput("stallCycles", 32'(stalls), 32'(expStall));
    checkOutput("memTxns", 32'(txns), hitExp ? 32'd0 : (wbExp ? 32'd2 : 32'd1));
    if (!hitExp) begin
      mValid[idx] = 1'b1;
      mDirty[idx] = 1'b0;
      mTag[idx]   = tg;
      mData[idx]  = memRead(lineAddr);
    end
    if (wr) begin
      mData[idx]  = wdata;
      mDirty[idx] = 1'b1;
    end else begin
      checkOutput("loadData", rdata, mData[idx]);
    end
  endtask

  // Abort a fetch with reset asserted in the same cycle as its ack.
  task automatic resetDuringFetch(input logic [31:0] addr);
    bit sawReq;
    sawReq      = 1'b0;
    ackDelay    = 2;
    cpu_req_i   = 1'b1;
    cpu_write_i = 1'b0;
    cpu_addr_i  = addr;
    for (int cyc = 0; cyc < 10 && !sawReq; cyc++) begin
      #1;
      if (mem_req_o) sawReq = 1'b1;
      else begin
        @(posedge clk_i);
        @(negedge clk_i);
      end
    end
    checkOutput("fetchSeen", 32'(sawReq), 32'd1);
    rst_i       = 1'b1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0_BAD0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i     = 1'b0;
    mem_ack_i = 1'b0;
    cpu_req_i = 1'b0;
    #1;
    checkOutput("reqDropAfterReset", 32'(mem_req_o), 32'd0);
    checkOutput("stallAfterReset", 32'(cpu_stall_o), 32'd0);
    @(negedge clk_i);
    modelReset();
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    modelReset();
    @(negedge clk_i);
    doReset(3);

    bmem[32'h40] = 32'hDEAD_BEEF;
    bmem[32'h80] = 32'hCAFE_F00D;
    ackDelay = 2;
    applyStimulus(1'b0, 32'h40, 32'h0, rd);
    checkOutput("coldLoad", rd, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h40, 32'h0, rd);
    checkOutput("repeatLoad", rd, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h40, 32'h1234_5678, rd);
    applyStimulus(1'b0, 32'h40, 32'h0, rd);
    checkOutput("loadAfterStore", rd, 32'h1234_5678);
    applyStimulus(1'b0, 32'h80, 32'h0, rd);
    checkOutput("conflictLoad", rd, 32'hCAFE_F00D);
    checkOutput("victimWrittenBack", memRead(32'h40), 32'h1234_5678);
    applyStimulus(1'b1, 32'h44, 32'hAABB_CCDD, rd);
    applyStimulus(1'b0, 32'h44, 32'h0, rd);
    checkOutput("storeMissData", rd, 32'hAABB_CCDD);
    applyStimulus(1'b0, 32'hC4, 32'h0, rd);

    idleCheck(8, 1'b1);
    resetDuringFetch(32'h40);
    applyStimulus(1'b0, 32'h40, 32'h0, rd);
    checkOutput("loadAfterAbort", rd, 32'h1234_5678);

    for (int n = 0; n < 300; n++) begin
      ackDelay = $urandom_range(1, 3);
      addr = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      applyStimulus(1'($urandom), addr, $urandom, rd);
      if ($urandom_range(0, 4) == 0) idleCheck($urandom_range(1, 3), 1'b1);
      if ($urandom_range(0, 59) == 0) doReset(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped one-word cache lines (power of two, >=2).
REQ-002 Parameter IDX_W, default 4, index width (=log2 LINES); tag = addr[31:IDX_W+2].
REQ-003 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 cpu_req_i  input  1  CPU access valid this cycle.
REQ-006 cpu_write_i  input  1  1=store, 0=load; qualified by cpu_req_i.
REQ-007 cpu_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata_i  input  32  store data.
REQ-009 cpu_rdata_o  output  32  load data, valid when cpu_req_i & !cpu_write_i & !cpu_stall_o.
REQ-010 cpu_stall_o  output  1  access not completing this cycle; CPU holds all cpu_* inputs stable.
REQ-011 mem_req_o  output  1  backing-memory request.
REQ-012 mem_write_o  output  1  1=writeback, 0=line fetch.
REQ-013 mem_addr_o  output  32  word-aligned backing-memory address.
REQ-014 mem_wdata_o  output  32  writeback data.
REQ-015 mem_rdata_i  input  32  fetch data, sampled when mem_ack_i=1.
REQ-016 mem_ack_i  input  1  one-cycle completion pulse from backing memory.

Function
REQ-017 Per line: valid bit, dirty bit, tag, 32-bit data word.
REQ-018 Hit = cpu_req_i & valid[idx] & tag[idx]==addr tag, evaluated combinationally in IDLE.
REQ-019 Read hit: cpu_stall_o=0, cpu_rdata_o=data[idx] same cycle (zero-wait).
REQ-020 Write hit: cpu_stall_o=0; data[idx]<=cpu_wdata_i and dirty[idx]<=1 at the next edge.
REQ-021 Miss in IDLE: cpu_stall_o=1 same cycle; next state WRITEBACK if valid[idx]&dirty[idx], else FETCH.
REQ-022 FSM states: IDLE, WRITEBACK, FETCH, REFILL.
REQ-023 WRITEBACK: mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag,idx,2'b00}, mem_wdata_o=data[idx]; held stable until mem_ack_i; on ack -> FETCH, dirty[idx]<=0.
REQ-024 FETCH: mem_req_o=1, mem_write_o=0, mem_addr_o={addr[31:2],2'b00}; held until mem_ack_i; on ack data[idx]<=mem_rdata_i, tag<=addr tag, valid<=1, dirty<=0 -> REFILL.
REQ-025 REFILL: mem_req_o=0, cpu_stall_o=1 for exactly one cycle, then IDLE where the held access re-evaluates as a hit.
REQ-026 Write miss is write-allocate: fetch line, then complete as write hit in IDLE.
REQ-027 cpu_stall_o=1 in every non-IDLE state; mem_req_o=0 in IDLE and REFILL.
REQ-028 mem_ack_i ignored when mem_req_o=0; ack in the first request cycle accepted (min miss latency: clean 3 cycles, dirty 4).
REQ-029 mem_ack_i latency unbounded; no timeout.
REQ-030 cpu_req_i=0 in IDLE: cpu_stall_o=0, no state change; cpu_rdata_o don't-care.
REQ-031 Idle outputs mem_addr_o, mem_wdata_o driven 0.

Reset
REQ-032 rst_i=1 at an edge: state<=IDLE, all valid<=0, all dirty<=0; tag/data arrays not reset.
REQ-033 During/after reset: mem_req_o=0, mem_write_o=0, cpu_stall_o=0 when cpu_req_i=0.
REQ-034 Reset mid-WRITEBACK/FETCH aborts the transaction; mem_req_o drops the cycle after the reset edge; dirty data lost by design.
REQ-035 rst_i takes priority over mem_ack_i in the same cycle.

Structure
REQ-036 Package dcache_pkg holds the state enum and the DCACHE default LINES/IDX_W constants.
REQ-037 One sub-module natural: dcache_array (valid/dirty/tag/data storage, combinational read, synchronous write).
REQ-038 FSM and hit logic in dcache_ctrl; no other hierarchy.

Verification (LINES=16; memory model acks after 2 cycles)
REQ-039 Cold load 0x0000_0040 after reset (mem[0x40]=0xDEAD_BEEF) -> one FETCH at 0x40, stall 4 cycles, rdata 0xDEAD_BEEF; repeat load -> stall 0.
REQ-040 Store 0x1234_5678 to 0x40 after fill -> no mem_req_o; load 0x40 returns 0x1234_5678.
REQ-041 Then load 0x0000_0080 (same index 0, different tag) -> WRITEBACK addr 0x40 data 0x1234_5678, then FETCH addr 0x80, correct rdata.
REQ-042 Store miss to 0x0000_0044 -> FETCH 0x44, then line dirty holding store data, no writeback issued.
REQ-043 Assert rst_i during FETCH wait -> mem_req_o 0 next cycle; load 0x40 afterwards misses (valid cleared).
REQ-044 mem_ack_i pulsed while IDLE -> no state/array change.
